seq_checker: RTL

Sequence checker on the receiving end of the 3-bit custom-sequence counter in the f_counter directory. Samples the counter's three state bits each cycle, locks to the 0→2→7→5→6→0 sequence, reports decoded position, and flags out-of-sequence steps and illegal codes (1, 3, 4). Sits beside the counter on the same clock as a self-check/monitor block.

---
 rtl/seq_chk_pkg.sv | 60 ++++++
 rtl/seq_chk_decode.sv | 27 ++
 rtl/seq_checker.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/seq_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_chk_pkg
// Description : Shared definitions for the sequence checker: FSM state
//               encoding, the five legal counter codes, the position marker
//               used while unlocked, and helpers that map a code to its
//               position and to the code that must follow it.
//               Sequence walked by the counter: 0 -> 2 -> 7 -> 5 -> 6 -> 0.
// Revision    : 1.0  initial release
// ============================================================================
package seq_chk_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t HUNT   = 2'd0;
    localparam state_t VERIFY = 2'd1;
    localparam state_t LOCK   = 2'd2;

    // Legal codes in sequence order ({q_a,q_b,q_c})
    localparam logic [2:0] CODE_P0 = 3'b000;
    localparam logic [2:0] CODE_P1 = 3'b010;
    localparam logic [2:0] CODE_P2 = 3'b111;
    localparam logic [2:0] CODE_P3 = 3'b101;
    localparam logic [2:0] CODE_P4 = 3'b110;

    // Position reported whenever the checker is not locked
    localparam logic [2:0] POS_NONE = 3'b111;

    function automatic logic is_legal(input logic [2:0] code);
        case (code)
            CODE_P0, CODE_P1, CODE_P2, CODE_P3, CODE_P4: is_legal = 1'b1;
            default:                                     is_legal = 1'b0;
        endcase
    endfunction

    // Successor of a legal code; illegal codes have no successor and map to
    // CODE_P0, which is harmless because prev only ever holds legal codes.
    function automatic logic [2:0] next_code(input logic [2:0] code);
        case (code)
            CODE_P0: next_code = CODE_P1;
            CODE_P1: next_code = CODE_P2;
            CODE_P2: next_code = CODE_P3;
            CODE_P3: next_code = CODE_P4;
            default: next_code = CODE_P0;
        endcase
    endfunction

    function automatic logic [2:0] code_to_pos(input logic [2:0] code);
        case (code)
            CODE_P0: code_to_pos = 3'd0;
            CODE_P1: code_to_pos = 3'd1;
            CODE_P2: code_to_pos = 3'd2;
            CODE_P3: code_to_pos = 3'd3;
            CODE_P4: code_to_pos = 3'd4;
            default: code_to_pos = POS_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_chk_decode.sv
`default_nettype none
// ============================================================================
// Module      : seq_chk_decode
// Description : Combinational code decoder for the sequence checker.
// Ports       : code     in  3  current sampled code {q_a,q_b,q_c}
//               prev     in  3  previously accepted legal code
//               legal    out 1  code is one of 0,2,7,5,6
//               position out 3  sequence index of code (POS_NONE if illegal)
//               follows  out 1  code is the legal successor of prev
// Revision    : 1.0  initial release
// ============================================================================
module seq_chk_decode
    import seq_chk_pkg::*;
(
    input  logic [2:0] code,
    input  logic [2:0] prev,
    output logic       legal,
    output logic [2:0] position,
    output logic       follows
);

    assign legal    = is_legal(code);
    assign position = code_to_pos(code);
    assign follows  = (code == next_code(prev));

endmodule
`default_nettype wire

// File: rtl/seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : seq_checker
// Description : Monitor for the 3-bit custom-sequence counter. Locks onto the
//               0->2->7->5->6->0 sequence after LOCK_COUNT consecutive correct
//               transitions, reports the decoded position while locked, and
//               pulses on out-of-sequence steps (while locked) and on illegal
//               codes 1, 3, 4. All outputs are registered (latency 1).
// Ports       : clk       in  1      rising-edge clock
//               rst       in  1      synchronous active-high reset
//               in_valid  in  1      sample qualifier; low holds all state
//               q_a/q_b/q_c in 1     counter bits, q_a is the code MSB
//               locked    out 1      high while in LOCK
//               pos       out 3      sequence index when locked, else 3'b111
//               err_pulse out 1      one-cycle pulse on loss of lock
//               illegal   out 1      one-cycle pulse on illegal valid code
//               err_cnt   out ERR_W  saturating lock-loss count
//                                    (present only with SEQ_CHK_ERRCNT_EN)
// Macro       : SEQ_CHK_ERRCNT_EN enables the err_cnt port and register.
// Revision    : 1.0  initial release
// ============================================================================
module seq_checker
    import seq_chk_pkg::*;
#(
    parameter int LOCK_COUNT = 3,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             q_a,
    input  logic             q_b,
    input  logic             q_c,
    output logic             locked,
    output logic [2:0]       pos,
    output logic             err_pulse,
`ifdef SEQ_CHK_ERRCNT_EN
    output logic [ERR_W-1:0] err_cnt,
`endif
    output logic             illegal
);

    // match_cnt never exceeds LOCK_COUNT, so this width always suffices.
    localparam int MC_W = $clog2(LOCK_COUNT + 1);

    logic [2:0]      w_code;
    logic            w_legal;
    logic [2:0]      w_position;
    logic            w_follows;

    state_t          r_state;
    logic [2:0]      r_prev;
    logic [MC_W-1:0] r_match_cnt;
    logic            r_locked;
    logic [2:0]      r_pos;
    logic            r_err_pulse;
    logic            r_illegal;

    state_t          w_state_nxt;
    logic [2:0]      w_prev_nxt;
    logic [MC_W-1:0] w_mc_nxt;
    logic [MC_W-1:0] w_mc_inc;
    logic [2:0]      w_pos_nxt;
    logic            w_err;
    logic            w_ill;

    assign w_code   = {q_a, q_b, q_c};
    assign w_mc_inc = r_match_cnt + MC_W'(1);

    seq_chk_decode u_decode (
        .code     (w_code),
        .prev     (r_prev),
        .legal    (w_legal),
        .position (w_position),
        .follows  (w_follows)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_mc_nxt    = r_match_cnt;
        w_pos_nxt   = r_pos;
        w_err       = 1'b0;
        w_ill       = 1'b0;

        if (in_valid) begin
            case (r_state)
                HUNT: begin
                    if (w_legal) begin
                        w_state_nxt = VERIFY;
                        w_prev_nxt  = w_code;
                        w_mc_nxt    = '0;
                    end else begin
                        w_ill = 1'b1;
                    end
                end
                VERIFY: begin
                    if (!w_legal) begin
                        w_state_nxt = HUNT;
                        w_mc_nxt    = '0;
                        w_ill       = 1'b1;
                    end else if (w_follows) begin
                        w_prev_nxt = w_code;
                        if (w_mc_inc == MC_W'(LOCK_COUNT)) begin
                            w_state_nxt = LOCK;
                            w_mc_nxt    = '0;
                        end else begin
                            w_mc_nxt = w_mc_inc;
                        end
                    end else begin
                        // Legal but out of order: restart counting from here.
                        w_prev_nxt = w_code;
                        w_mc_nxt   = '0;
                    end
                end
                LOCK: begin
                    if (!w_legal) begin
                        w_state_nxt = HUNT;
                        w_mc_nxt    = '0;
                        w_err       = 1'b1;
                        w_ill       = 1'b1;
                    end else if (w_follows) begin
                        w_prev_nxt = w_code;
                    end else begin
                        w_state_nxt = VERIFY;
                        w_prev_nxt  = w_code;
                        w_mc_nxt    = '0;
                        w_err       = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_mc_nxt    = '0;
                end
            endcase
            w_pos_nxt = (w_state_nxt == LOCK) ? w_position : POS_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_prev      <= CODE_P0;
            r_match_cnt <= '0;
            r_locked    <= 1'b0;
            r_pos       <= POS_NONE;
            r_err_pulse <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= w_prev_nxt;
            r_match_cnt <= w_mc_nxt;
            r_locked    <= (w_state_nxt == LOCK);
            r_pos       <= w_pos_nxt;
            r_err_pulse <= w_err;
            r_illegal   <= w_ill;
        end
    end

    assign locked    = r_locked;
    assign pos       = r_pos;
    assign err_pulse = r_err_pulse;
    assign illegal   = r_illegal;

`ifdef SEQ_CHK_ERRCNT_EN
    logic [ERR_W-1:0] r_err_cnt;

    // Counts lock losses; an illegal code that also drops lock counts once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_err && (r_err_cnt != {ERR_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    // ERR_W only sizes err_cnt; referenced here so the parameter stays
    // meaningful in builds without the counter.
    if (ERR_W < 1) begin : g_errw_unused
    end
`endif

endmodule
`default_nettype wire
